issue_ctrl: RTL
===============

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 8, number of reorder-buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter RS_PER_CLASS, default 3, reservation-station slots per unit class (add, mul, bch).
REQ-003 SHALL have parameter NREGS, default 16, architectural registers; TAG_W = clog2(ROB_DEPTH) is derived, not set.
REQ-004 SHALL have ports:
  clk1  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  decoded instruction present
  in_ready  out  1  issue can accept this cycle
  in_func  in  4  opcode
  in_rd / in_rs1 / in_rs2  in  4 each  register indices
  commit_valid  in  1  ROB head retires this cycle
  rs_free  in  3  per-class slot release: bit0 add, bit1 mul, bit2 bch
  flush  in  1  synchronous squash of all speculative state
  iss_valid  out  1  registered issue packet valid
  iss_tag  out  TAG_W  allocated ROB index
  iss_class  out  2  0 add, 1 mul, 2 bch
  iss_func / iss_rd  out  4 each  passthrough
  iss_rs1_tag / iss_rs2_tag  out  TAG_W  producer ROB index
  iss_rs1_busy / iss_rs2_busy  out  1  operand awaits producer
  illegal  out  1  one-cycle pulse, rejected opcode
  rob_count  out  TAG_W+1  occupied ROB entries
  head_tag  out  TAG_W  oldest ROB index

Function
REQ-005 Class decode SHALL be: 000x add, 001x mul, 01xx bch, 1xxx illegal.
REQ-006 in_ready SHALL be combinational: high iff flush low, rob_count < ROB_DEPTH, and the decoded class has count < RS_PER_CLASS; illegal opcodes SHALL see in_ready high whenever flush is low.
REQ-007 Handshake (in_valid & in_ready) on a legal opcode SHALL allocate ROB[tail], increment tail mod ROB_DEPTH, increment rob_count and the class count.
REQ-008 Handshake on illegal opcode SHALL allocate nothing and pulse illegal the next cycle; iss_valid stays low.
REQ-009 Issue packet SHALL appear exactly 1 cycle after handshake; iss_valid high for one cycle per accepted legal instruction.
REQ-010 Operand tags/busy SHALL be read from the rename table before this cycle's rd update (rs1==rd sees old mapping).
REQ-011 add/mul issue SHALL set rename busy[rd]=1, tag[rd]=allocated index, and store rd in the ROB entry; bch SHALL not touch the rename table.
REQ-012 commit_valid with rob_count>0 SHALL advance head mod ROB_DEPTH, decrement rob_count, and clear busy[rd_head] only if tag[rd_head]==head index; commit on empty SHALL be ignored.
REQ-013 Same-cycle commit clearing and issue setting the same register SHALL leave busy=1 with the new tag (issue wins).
REQ-014 Same-cycle allocate and commit SHALL leave rob_count unchanged; ROB_DEPTH full plus commit SHALL still block issue that cycle (in_ready uses registered count).
REQ-015 rs_free bit for a class with count 0 SHALL be ignored; simultaneous allocate and free in one class SHALL net to no change.
REQ-016 Pointers SHALL wrap silently; full/empty derived from rob_count only.
REQ-017 flush SHALL, next edge, zero head, tail, rob_count, all class counts and all busy bits, drive iss_valid/illegal low, and override any same-cycle handshake, commit or free.

Reset
REQ-018 rst_n low SHALL immediately clear head, tail, rob_count, class counts, busy bits, iss_valid, illegal, and all iss_* fields to 0, including mid-operation; in_ready then reflects empty state.
REQ-019 First edge after rst_n rises SHALL accept a valid instruction normally.

Verification
REQ-020 Reset, issue add r3=r1+r2 -> next cycle iss_valid=1, tag=0, class=0, both busy=0; busy[r3]=1 tag 0.
REQ-021 Issue 3 adds then a 4th add with in_valid held -> in_ready=0 on 4th; mul issues same cycle accepted; rs_free[0] pulse -> 4th add accepted next cycle.
REQ-022 Fill 8 entries (mixed classes, frees applied) -> in_ready=0, rob_count=8; commit -> count 7, next issue gets tag 0 (wrap).
REQ-023 Issue r5=..(tag 0), then r5=..(tag 1), commit tag 0 -> busy[r5] stays 1 tag 1; consumer of r5 sees tag 1 busy.
REQ-024 opcode 4'b1010 -> illegal pulse, rob_count unchanged, no iss_valid.
REQ-025 Flush with handshake and commit asserted at rob_count=5 -> next cycle rob_count=0, all busy 0, iss_valid=0; rst_n pulse mid-stream -> outputs 0 without clock edge.

Source files
------------

// File: rtl/issue_ctrl.sv
// In-order issue controller: opcode class decode, ROB tag allocation,
// register rename table and per-class reservation-station occupancy.
module issue_ctrl #(
  parameter int ROB_DEPTH    = 8,
  parameter int RS_PER_CLASS = 3,
  parameter int NREGS        = 16,
  localparam int TAG_W       = $clog2(ROB_DEPTH)
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rs1,
  input  logic [3:0]       in_rs2,
  input  logic             commit_valid,
  input  logic [2:0]       rs_free,
  input  logic             flush,
  output logic             iss_valid,
  output logic [TAG_W-1:0] iss_tag,
  output logic [1:0]       iss_class,
  output logic [3:0]       iss_func,
  output logic [3:0]       iss_rd,
  output logic [TAG_W-1:0] iss_rs1_tag,
  output logic [TAG_W-1:0] iss_rs2_tag,
  output logic             iss_rs1_busy,
  output logic             iss_rs2_busy,
  output logic             illegal,
  output logic [TAG_W:0]   rob_count,
  output logic [TAG_W-1:0] head_tag
);

  localparam int REG_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(RS_PER_CLASS + 1);

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_BCH = 2'd2
  } cls_e;

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic [CNT_W-1:0] r_cls_cnt [3];
  logic [NREGS-1:0] r_busy;
  logic [TAG_W-1:0] r_tag [NREGS];
  logic [REG_W-1:0] r_rob_rd [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] r_rob_wr;

  cls_e             w_cls;
  logic             w_illegal_op;
  logic             w_rob_full;
  logic             w_cls_full;
  logic             w_fire;
  logic             w_alloc;
  logic             w_writes;
  logic             w_commit;
  logic             w_head_clr;
  logic [REG_W-1:0] w_head_rd;
  logic [REG_W-1:0] w_rd;
  logic [2:0]       w_inc;
  logic [2:0]       w_dec;

  // 000x add, 001x mul, 01xx bch, 1xxx illegal
  always_comb begin
    w_illegal_op = in_func[3];
    w_cls        = CLS_ADD;
    if (in_func[2])      w_cls = CLS_BCH;
    else if (in_func[1]) w_cls = CLS_MUL;
  end

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_cls_full = 1'b0;
    w_inc      = '0;
    w_dec      = '0;
    for (int c = 0; c < 3; c++) begin
      if (w_cls == cls_e'(c) && r_cls_cnt[c] >= CNT_W'(RS_PER_CLASS))
        w_cls_full = 1'b1;
      w_inc[c] = w_alloc && (w_cls == cls_e'(c));
      w_dec[c] = rs_free[c] && (r_cls_cnt[c] != '0);
    end
  end

  assign w_rob_full = (r_count >= (TAG_W+1)'(ROB_DEPTH));
  assign in_ready   = !flush && (w_illegal_op || (!w_rob_full && !w_cls_full));
  assign w_fire     = in_valid && in_ready;
  assign w_alloc    = w_fire && !w_illegal_op;
  assign w_writes   = w_alloc && (w_cls != CLS_BCH);
  assign w_rd       = in_rd[REG_W-1:0];

  assign w_commit   = commit_valid && (r_count != '0);
  assign w_head_rd  = r_rob_rd[r_head];
  // Only the newest producer of a register may release it.
  assign w_head_clr = w_commit && r_rob_wr[r_head] && (r_tag[w_head_rd] == r_head);

  // NOTE: the ROB destination array holds no control state (it is only read
  // for occupied entries), so it is left out of reset and kept in a plain
  // clocked block.
  always_ff @(posedge clk1) begin
    if (w_alloc) r_rob_rd[r_tail] <= w_rd;
  end

  // NOTE: all state uses non-blocking assignments; where two assignments hit
  // the same register in one edge, the later one (issue after commit) wins.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_busy       <= '0;
      r_rob_wr     <= '0;
      for (int c = 0; c < 3; c++) r_cls_cnt[c] <= '0;
      for (int r = 0; r < NREGS; r++) r_tag[r] <= '0;
      iss_valid    <= 1'b0;
      illegal      <= 1'b0;
      iss_tag      <= '0;
      iss_class    <= '0;
      iss_func     <= '0;
      iss_rd       <= '0;
      iss_rs1_tag  <= '0;
      iss_rs2_tag  <= '0;
      iss_rs1_busy <= 1'b0;
      iss_rs2_busy <= 1'b0;
    end else if (flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      for (int c = 0; c < 3; c++) r_cls_cnt[c] <= '0;
      iss_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      iss_valid <= w_alloc;
      illegal   <= w_fire && w_illegal_op;

      if (w_alloc) begin
        r_tail           <= r_tail + TAG_W'(1);
        r_rob_wr[r_tail] <= w_writes;
        iss_tag          <= r_tail;
        iss_class        <= w_cls;
        iss_func         <= in_func;
        iss_rd           <= in_rd;
        iss_rs1_tag      <= r_tag[in_rs1[REG_W-1:0]];
        iss_rs2_tag      <= r_tag[in_rs2[REG_W-1:0]];
        iss_rs1_busy     <= r_busy[in_rs1[REG_W-1:0]];
        iss_rs2_busy     <= r_busy[in_rs2[REG_W-1:0]];
      end

      if (w_commit) r_head <= r_head + TAG_W'(1);

      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase

      for (int c = 0; c < 3; c++) begin
        case ({w_inc[c], w_dec[c]})
          2'b10:   r_cls_cnt[c] <= r_cls_cnt[c] + CNT_W'(1);
          2'b01:   r_cls_cnt[c] <= r_cls_cnt[c] - CNT_W'(1);
          default: r_cls_cnt[c] <= r_cls_cnt[c];
        endcase
      end

      if (w_head_clr) r_busy[w_head_rd] <= 1'b0;
      if (w_writes) begin
        r_busy[w_rd] <= 1'b1;
        r_tag[w_rd]  <= r_tail;
      end
    end
  end

  assign rob_count = r_count;
  assign head_tag  = r_head;

endmodule
